// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control sequencer.
// Fetches into an internal instruction register, then walks DECODE/EXEC/MEM/WB
// and raises the datapath strobes for each step. Memory and MMIO accesses use
// ready handshakes guarded by a wait-cycle timeout. Unknown opcodes, SYSTEM
// instructions and bus timeouts park the controller in HALT until reset.
module multicycle_controller #(
    parameter int unsigned           IO_HI_BITS  = 16,
    parameter logic [IO_HI_BITS-1:0] IO_ADDR_HI  = 16'hFFFF,
    parameter int unsigned           MEM_TIMEOUT = 255,
    parameter int unsigned           CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst_in,
    input  logic [31:0]      addr,
    input  logic             mem_ready,
    input  logic             io_ready,
    output logic [3:0]       ALUOp,
    output logic [2:0]       ALUSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             ioRead,
    output logic             ioWrite,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             is_signed,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    // Opcode encodings recognised by the decoder
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SRL  = 4'd3;
    localparam logic [3:0] ALU_SRA  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_BEQ  = 4'd8;
    localparam logic [3:0] ALU_BNE  = 4'd9;
    localparam logic [3:0] ALU_LT   = 4'd10;
    localparam logic [3:0] ALU_GE   = 4'd11;
    localparam logic [3:0] ALU_LTU  = 4'd12;
    localparam logic [3:0] ALU_GEU  = 4'd13;

    // ALU operand-B source selects
    localparam logic [2:0] SRC_RS2   = 3'd0;
    localparam logic [2:0] SRC_IMM   = 3'd1;
    localparam logic [2:0] SRC_PC4   = 3'd2;
    localparam logic [2:0] SRC_LUI   = 3'd3;
    localparam logic [2:0] SRC_AUIPC = 3'd4;
    localparam logic [2:0] SRC_SHAMT = 3'd5;

    localparam logic [31:0] IR_RESET = 32'h0000_0013;

    // Wait counter sized to hold MEM_TIMEOUT; expiry is detected one count early
    // so the HALT transition lands on the MEM_TIMEOUT-th non-ready cycle.
    localparam int unsigned         WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // ALU operation for the instruction held in IR
    function automatic logic [3:0] alu_op_f(input logic [31:0] ir);
        logic [3:0] op;
        logic       alt;
        op  = ALU_ADD;
        alt = (ir[31:25] == 7'h20);
        case (ir[6:0])
            OP_R, OP_I: begin
                case (ir[14:12])
                    3'd0:    op = (alt && (ir[6:0] == OP_R)) ? ALU_SUB : ALU_ADD;
                    3'd1:    op = ALU_SLL;
                    3'd2:    op = ALU_LT;
                    3'd3:    op = ALU_LTU;
                    3'd4:    op = ALU_XOR;
                    3'd5:    op = alt ? ALU_SRA : ALU_SRL;
                    3'd6:    op = ALU_OR;
                    3'd7:    op = ALU_AND;
                    default: op = ALU_ADD;
                endcase
            end
            OP_BRANCH: begin
                case (ir[14:12])
                    3'd0:    op = ALU_BEQ;
                    3'd1:    op = ALU_BNE;
                    3'd4:    op = ALU_LT;
                    3'd5:    op = ALU_GE;
                    3'd6:    op = ALU_LTU;
                    3'd7:    op = ALU_GEU;
                    default: op = ALU_ADD;
                endcase
            end
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Operand-B source for the instruction held in IR
    function automatic logic [2:0] alu_src_f(input logic [31:0] ir);
        logic [2:0] src;
        src = SRC_RS2;
        case (ir[6:0])
            OP_R, OP_BRANCH:   src = SRC_RS2;
            OP_I:              src = ((ir[14:12] == 3'd1) || (ir[14:12] == 3'd5)) ? SRC_SHAMT : SRC_IMM;
            OP_LOAD, OP_STORE: src = SRC_IMM;
            OP_JAL, OP_JALR:   src = SRC_PC4;
            OP_LUI:            src = SRC_LUI;
            OP_AUIPC:          src = SRC_AUIPC;
            default:           src = SRC_RS2;
        endcase
        return src;
    endfunction

    // True for opcodes that proceed to EXEC
    function automatic logic op_known_f(input logic [6:0] opc);
        logic known;
        case (opc)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: known = 1'b1;
            default:                           known = 1'b0;
        endcase
        return known;
    endfunction

    state_t             state_q, state_d;
    logic [31:0]        ir_q, ir_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       is_load_s, is_store_s, is_branch_s, is_jump_s;
    logic       io_sel_s, ready_s, wait_last_s;

    logic ir_write_s, pc_write_s, branch_s, mem_read_s, mem_write_s;
    logic io_read_s, io_write_s, reg_write_s, mem_to_reg_s, is_signed_s;

    // Fields of IR that the controller never looks at
    logic unused_s;
    assign unused_s = ^{ir_q[24:15], ir_q[11:7], addr[31-IO_HI_BITS:0]};

    assign opcode_s    = ir_q[6:0];
    assign funct3_s    = ir_q[14:12];
    assign is_load_s   = (opcode_s == OP_LOAD);
    assign is_store_s  = (opcode_s == OP_STORE);
    assign is_branch_s = (opcode_s == OP_BRANCH);
    assign is_jump_s   = (opcode_s == OP_JAL) || (opcode_s == OP_JALR);
    assign io_sel_s    = (addr[31 -: IO_HI_BITS] == IO_ADDR_HI);
    assign ready_s     = io_sel_s ? io_ready : mem_ready;
    assign wait_last_s = (wait_q == WAIT_LAST);

    // Per-state strobes decoded from the current state and IR
    always_comb begin
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        branch_s     = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        io_read_s    = 1'b0;
        io_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        is_signed_s  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_s = 1'b1;
                ir_write_s = mem_ready;
            end
            S_EXEC: begin
                if (is_branch_s) begin
                    branch_s   = 1'b1;
                    pc_write_s = 1'b1;
                end else if (is_jump_s) begin
                    branch_s   = 1'b1;
                end else begin
                    branch_s   = 1'b0;
                end
            end
            S_MEM: begin
                if (is_load_s) begin
                    io_read_s  = io_sel_s;
                    mem_read_s = !io_sel_s;
                end else begin
                    io_write_s  = io_sel_s;
                    mem_write_s = !io_sel_s;
                    pc_write_s  = ready_s;
                end
            end
            S_WB: begin
                reg_write_s  = 1'b1;
                pc_write_s   = 1'b1;
                branch_s     = is_jump_s;
                mem_to_reg_s = is_load_s;
                is_signed_s  = is_load_s && ((funct3_s == 3'd0) || (funct3_s == 3'd1));
            end
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    // Strobes are forced low for as long as reset is asserted
    assign IRWrite   = ir_write_s   & rst_n;
    assign PCWrite   = pc_write_s   & rst_n;
    assign Branch    = branch_s     & rst_n;
    assign MemRead   = mem_read_s   & rst_n;
    assign MemWrite  = mem_write_s  & rst_n;
    assign ioRead    = io_read_s    & rst_n;
    assign ioWrite   = io_write_s   & rst_n;
    assign RegWrite  = reg_write_s  & rst_n;
    assign MemtoReg  = mem_to_reg_s & rst_n;
    assign is_signed = is_signed_s  & rst_n;

    assign ALUOp   = alu_op_f(ir_q);
    assign ALUSrc  = alu_src_f(ir_q);
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign retired = retired_q;
    assign state   = state_q;

    // Next-state, IR capture, wait-counter and halt-cause logic
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        if (pc_write_s) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_d = retired_q;
        end
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = inst_in;
                    wait_d  = '0;
                    state_d = S_DECODE;
                end else if (wait_last_s) begin
                    wait_d    = '0;
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
                end
            end
            S_DECODE: begin
                wait_d = '0;
                if (op_known_f(opcode_s)) begin
                    state_d = S_EXEC;
                end else if (opcode_s == OP_SYSTEM) begin
                    state_d = S_HALT;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC: begin
                wait_d = '0;
                if (is_branch_s) begin
                    state_d = S_FETCH;
                end else if (is_load_s || is_store_s) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (ready_s) begin
                    wait_d  = '0;
                    state_d = is_load_s ? S_WB : S_FETCH;
                end else if (wait_last_s) begin
                    wait_d    = '0;
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
                end
            end
            S_WB: begin
                wait_d  = '0;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Controller state registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ir_q      <= IR_RESET;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with hand-computed expectations.
module tb_multicycle_controller;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_in;
    logic [31:0] addr;
    logic        mem_ready;
    logic        io_ready;
    logic [3:0]  ALUOp;
    logic [2:0]  ALUSrc;
    logic        IRWrite, PCWrite, Branch, MemRead, MemWrite;
    logic        ioRead, ioWrite, RegWrite, MemtoReg, is_signed;
    logic        halted, illegal, bus_err;
    logic [31:0] retired;
    logic [2:0]  state;

    int checks_s;
    int errors_s;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0020A283;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_JAL  = 32'h000000EF;
    localparam logic [31:0] I_SRAI = 32'h4030D093;

    multicycle_controller #(
        .IO_HI_BITS (16),
        .IO_ADDR_HI (16'hFFFF),
        .MEM_TIMEOUT(4),
        .CNT_W      (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inst_in  (inst_in),
        .addr     (addr),
        .mem_ready(mem_ready),
        .io_ready (io_ready),
        .ALUOp    (ALUOp),
        .ALUSrc   (ALUSrc),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .Branch   (Branch),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ioRead   (ioRead),
        .ioWrite  (ioWrite),
        .RegWrite (RegWrite),
        .MemtoReg (MemtoReg),
        .is_signed(is_signed),
        .halted   (halted),
        .illegal  (illegal),
        .bus_err  (bus_err),
        .retired  (retired),
        .state    (state)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_s++;
        if (obs !== exp) begin
            errors_s++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and stop on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        io_ready  = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // From FETCH with ready high, go to the DECODE negedge
    task automatic fetch(input logic [31:0] ins);
        inst_in   = ins;
        mem_ready = 1'b1;
        #1;
        check_eq("fetch_state", 32'(state), 32'd0);
        check_eq("fetch_irw", 32'(IRWrite), 32'd1);
        tick();
    endtask

    initial begin
        checks_s  = 0;
        errors_s  = 0;
        rst_n     = 1'b0;
        inst_in   = 32'h0;
        addr      = 32'h0;
        mem_ready = 1'b1;
        io_ready  = 1'b1;

        // Reset state: strobes stay low even with both readies high
        #2;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_memread", 32'(MemRead), 32'd0);
        check_eq("rst_irwrite", 32'(IRWrite), 32'd0);
        check_eq("rst_retired", retired, 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        do_reset();
        #1;
        check_eq("rel_memread", 32'(MemRead), 32'd1);

        // add: FETCH, DECODE, EXEC, WB
        fetch(I_ADD);
        check_eq("add_dec", 32'(state), 32'd1);
        tick();
        check_eq("add_exec", 32'(state), 32'd2);
        tick();
        check_eq("add_wb", 32'(state), 32'd4);
        check_eq("add_regw", 32'(RegWrite), 32'd1);
        check_eq("add_pcw", 32'(PCWrite), 32'd1);
        check_eq("add_aluop", 32'(ALUOp), 32'd0);
        check_eq("add_alusrc", 32'(ALUSrc), 32'd0);
        tick();
        check_eq("add_ret", retired, 32'd1);

        // lw from IO window, io_ready on 3rd MEM cycle; mem_ready ignored
        addr = 32'hFFFF0004;
        fetch(I_LW);
        tick();
        check_eq("lw_alusrc", 32'(ALUSrc), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            io_ready = (i == 2);
            #1;
            check_eq("lw_mem_state", 32'(state), 32'd3);
            check_eq("lw_ioread", 32'(ioRead), 32'd1);
            check_eq("lw_memread", 32'(MemRead), 32'd0);
            tick();
        end
        io_ready = 1'b0;
        check_eq("lw_wb", 32'(state), 32'd4);
        check_eq("lw_m2r", 32'(MemtoReg), 32'd1);
        check_eq("lw_signed", 32'(is_signed), 32'd0);
        check_eq("lw_regw", 32'(RegWrite), 32'd1);
        tick();
        check_eq("lw_ret", retired, 32'd2);

        // sw to memory, mem_ready delayed 2 cycles; io_ready ignored
        addr = 32'h00001000;
        fetch(I_SW);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            io_ready  = 1'b1;
            #1;
            check_eq("sw_memw", 32'(MemWrite), 32'd1);
            check_eq("sw_iow", 32'(ioWrite), 32'd0);
            check_eq("sw_regw", 32'(RegWrite), 32'd0);
            check_eq("sw_pcw", 32'(PCWrite), (i == 2) ? 32'd1 : 32'd0);
            tick();
        end
        io_ready = 1'b0;
        check_eq("sw_done_state", 32'(state), 32'd0);
        check_eq("sw_ret", retired, 32'd3);

        // beq: 3 cycles, branch strobes in EXEC
        fetch(I_BEQ);
        tick();
        check_eq("beq_aluop", 32'(ALUOp), 32'd8);
        check_eq("beq_branch", 32'(Branch), 32'd1);
        check_eq("beq_pcw", 32'(PCWrite), 32'd1);
        tick();
        check_eq("beq_state", 32'(state), 32'd0);
        check_eq("beq_ret", retired, 32'd4);

        // jal: Branch in EXEC and WB, pc+4 operand
        fetch(I_JAL);
        tick();
        check_eq("jal_exec_br", 32'(Branch), 32'd1);
        check_eq("jal_alusrc", 32'(ALUSrc), 32'd2);
        tick();
        check_eq("jal_wb_br", 32'(Branch), 32'd1);
        check_eq("jal_wb_regw", 32'(RegWrite), 32'd1);
        tick();

        // srai: arithmetic shift with shamt operand
        fetch(I_SRAI);
        check_eq("srai_aluop", 32'(ALUOp), 32'd4);
        check_eq("srai_alusrc", 32'(ALUSrc), 32'd5);
        tick();
        tick();
        tick();
        check_eq("srai_ret", retired, 32'd6);

        // Reset mid-MEM with MemWrite active
        fetch(I_SW);
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        check_eq("mid_memw_pre", 32'(MemWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_memw_rst", 32'(MemWrite), 32'd0);
        check_eq("mid_state_rst", 32'(state), 32'd0);
        check_eq("mid_ret_rst", retired, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_eq("mid_resume_state", 32'(state), 32'd0);
        check_eq("mid_resume_memread", 32'(MemRead), 32'd1);

        // Store timeout: no ready for 4 MEM cycles -> HALT with bus_err
        fetch(I_SW);
        tick();
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("to_mem_state", 32'(state), 32'd3);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check_eq("to_state", 32'(state), 32'd5);
        check_eq("to_buserr", 32'(bus_err), 32'd1);
        check_eq("to_halted", 32'(halted), 32'd1);
        check_eq("to_illegal", 32'(illegal), 32'd0);
        check_eq("to_memw", 32'(MemWrite), 32'd0);
        check_eq("to_memread", 32'(MemRead), 32'd0);
        check_eq("to_pcw", 32'(PCWrite), 32'd0);
        tick();
        check_eq("to_stays", 32'(state), 32'd5);

        // Ready on the 4th MEM cycle completes the store
        do_reset();
        fetch(I_SW);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            check_eq("late_state", 32'(state), 32'd3);
            tick();
        end
        check_eq("late_done", 32'(state), 32'd0);
        check_eq("late_buserr", 32'(bus_err), 32'd0);
        check_eq("late_ret", retired, 32'd1);

        // Unknown opcode -> illegal halt
        fetch(32'h0000007F);
        tick();
        check_eq("ill_state", 32'(state), 32'd5);
        check_eq("ill_flag", 32'(illegal), 32'd1);
        check_eq("ill_halted", 32'(halted), 32'd1);

        // SYSTEM -> halt without illegal
        do_reset();
        fetch(32'h00000073);
        tick();
        check_eq("sys_state", 32'(state), 32'd5);
        check_eq("sys_illegal", 32'(illegal), 32'd0);
        check_eq("sys_buserr", 32'(bus_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
        $finish;
    end

endmodule
